// File: rtl/hmi_pkg.sv
// Shared display constants, RGB565 colours and the line renderer FSM encoding.
package hmi_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_TOTAL  = 520;

  localparam logic [9:0] LAST_X = 10'(H_ACTIVE - 1);

  localparam logic [15:0] RGB_BLACK  = 16'h0000;
  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
  localparam logic [15:0] RGB_GREY   = 16'h4208;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } line_state_t;

endpackage

// File: rtl/wave_row_map.sv
// Maps each sample to its screen row and remembers the row of the previous
// pixel so the top can draw a vertical segment between neighbouring samples.
module wave_row_map import hmi_pkg::*; #(
  parameter logic [9:0] TOP_ROW = 10'd30,
  parameter logic [9:0] ROW_OFS = 10'd112
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       smp_vld,
  input  logic       first,
  input  logic [7:0] smp_q,
  output logic [9:0] row,
  output logic [9:0] prev_row
);

  logic [9:0] prev_r;

  // Larger samples sit higher on screen; ~smp_q is 255 - smp_q, and the sum
  // never exceeds 397 so 10 bits hold it without wrap.
  always_comb begin
    row      = TOP_ROW + ROW_OFS + {2'b00, ~smp_q};
    prev_row = first ? row : prev_r;
  end

  // Register the row of every valid sample; it becomes the previous row of the next pixel.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= '0;
    end else if (smp_vld) begin
      prev_r <= row;
    end
  end

endmodule

// File: rtl/wave_line_gen.sv
// Renders one 640-pixel waveform line into a line RAM per line_start request.
// Optional background grid is enabled by defining WAVE_GRID_EN.
//
// Handshake: line_start is a one-cycle request sampled with line_num. It is
// accepted when the block is idle or on the cycle done is high; otherwise it
// is dropped and overrun pulses combinationally in that same cycle. busy is
// high from the cycle after acceptance until the done cycle inclusive. Pixel
// x is written with ram_wen two cycles after smp_raddr = x is presented.
module wave_line_gen import hmi_pkg::*; #(
  parameter logic [9:0]  TOP_ROW   = 10'd30,
  parameter logic [9:0]  ROW_OFS   = 10'd112,
  parameter logic [15:0] TRACE_RGB = RGB_YELLOW,
  parameter logic [15:0] GRID_RGB  = RGB_GREY
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [9:0]  line_num,
  output logic [9:0]  smp_raddr,
  input  logic [7:0]  smp_q,
  output logic [9:0]  ram_waddr,
  output logic [15:0] ram_wdata,
  output logic        ram_wen,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  line_state_t state, state_nxt;

  logic        line_active;
  logic        accept;
  logic        start_line;
  logic        smp_vld;
  logic        first_px;
  logic [9:0]  pix_x;
  logic [9:0]  line_r;
  logic [9:0]  row;
  logic [9:0]  prev_row;
  logic [9:0]  span_lo;
  logic [9:0]  span_hi;
  logic        trace_hit;
  logic [15:0] bg_rgb;
  logic [15:0] pix_rgb;

  // Request decode: active-line window check, acceptance and overrun.
  always_comb begin
    line_active = ({1'b0, line_num} >= {1'b0, TOP_ROW}) &&
                  ({1'b0, line_num} <  ({1'b0, TOP_ROW} + 11'(V_ACTIVE)));
    accept      = line_start && ((state == IDLE) || done);
    start_line  = accept && line_active;
    overrun     = line_start && !accept;
    busy        = (state != IDLE);
    first_px    = smp_vld && (pix_x == 10'd0);
  end

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: FILL issues addresses, DRAIN waits for the pipeline to empty.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_line) state_nxt = FILL;
      FILL:    if (smp_raddr == LAST_X) state_nxt = DRAIN;
      DRAIN:   if (done) state_nxt = start_line ? FILL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address issue: address 0 is already on the bus while idle, so FILL starts at 1.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      smp_raddr <= '0;
      pix_x     <= '0;
      smp_vld   <= 1'b0;
      line_r    <= '0;
    end else begin
      pix_x   <= smp_raddr;
      smp_vld <= start_line || (state == FILL);
      if (start_line) begin
        line_r    <= line_num;
        smp_raddr <= 10'd1;
      end else if (state == FILL) begin
        smp_raddr <= (smp_raddr == LAST_X) ? 10'd0 : smp_raddr + 10'd1;
      end
    end
  end

  wave_row_map #(
    .TOP_ROW (TOP_ROW),
    .ROW_OFS (ROW_OFS)
  ) u_row_map (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .smp_vld  (smp_vld),
    .first    (first_px),
    .smp_q    (smp_q),
    .row      (row),
    .prev_row (prev_row)
  );

`ifdef WAVE_GRID_EN
  logic [9:0] line_rel;
  // Grid lines every 64 pixels horizontally and every 64 active lines vertically.
  always_comb begin
    line_rel = line_r - TOP_ROW;
    bg_rgb   = ((pix_x[5:0] == 6'd0) || (line_rel[5:0] == 6'd0)) ? GRID_RGB : RGB_BLACK;
  end
`else
  assign bg_rgb = RGB_BLACK;
`endif

  // Pixel colour: trace where the current line falls between the two neighbouring rows.
  always_comb begin
    span_lo   = (prev_row < row) ? prev_row : row;
    span_hi   = (prev_row < row) ? row : prev_row;
    trace_hit = (line_r >= span_lo) && (line_r <= span_hi);
    pix_rgb   = trace_hit ? TRACE_RGB : bg_rgb;
  end

  // Write port and end-of-line pulse; an inactive request completes immediately.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ram_wen   <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      done      <= 1'b0;
    end else begin
      ram_wen   <= smp_vld;
      ram_waddr <= smp_vld ? pix_x : 10'd0;
      ram_wdata <= smp_vld ? pix_rgb : RGB_BLACK;
      done      <= (ram_wen && (ram_waddr == LAST_X)) || (accept && !line_active);
    end
  end

endmodule

// File: tb/tb_wave_line_gen.sv
// Self-checking bench for wave_line_gen: per-cycle comparison against a
// line-level behavioural model plus literal checks on directed scenarios.
module tb_wave_line_gen;

  localparam logic [9:0]  TOP   = 10'd30;
  localparam logic [9:0]  OFS   = 10'd112;
  localparam logic [15:0] TRACE = 16'hFFE0;
  localparam logic [15:0] GRID  = 16'h4208;
  localparam int          NCYC  = 16384;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  line_num = '0;
  logic [9:0]  smp_raddr;
  logic [7:0]  smp_q = '0;
  logic [9:0]  ram_waddr;
  logic [15:0] ram_wdata;
  logic        ram_wen;
  logic        busy;
  logic        done;
  logic        overrun;

  wave_line_gen #(
    .TOP_ROW   (TOP),
    .ROW_OFS   (OFS),
    .TRACE_RGB (TRACE),
    .GRID_RGB  (GRID)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .line_start (line_start),
    .line_num   (line_num),
    .smp_raddr  (smp_raddr),
    .smp_q      (smp_q),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_wen    (ram_wen),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Sample buffer: synchronous read, data one cycle after the address.
  logic [7:0] smp_mem [640];
  always @(posedge clk_sys) smp_q <= smp_mem[smp_raddr];

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  bit        exp_busy  [NCYC];
  bit        exp_done  [NCYC];
  bit  [9:0] exp_raddr [NCYC];
  logic [25:0] exp_q[$];
  int          exp_cyc_q[$];

  int wr_cnt, trace_cnt, grid_cnt, zero_cnt, busy_cnt, ovr_cnt, ovr_cyc, done_cyc, start_cyc;
  logic [15:0] cap [640];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int row_of(input logic [7:0] s);
    return int'(TOP) + int'(OFS) + 255 - int'(s);
  endfunction

  function automatic logic [15:0] colour_of(input int x, input int prev, input int row, input int ln);
    int lo, hi;
    lo = (prev < row) ? prev : row;
    hi = (prev < row) ? row : prev;
    if (ln >= lo && ln <= hi) return TRACE;
`ifdef WAVE_GRID_EN
    if ((x % 64) == 0 || ((ln - int'(TOP)) % 64) == 0) return GRID;
`endif
    return 16'h0000;
  endfunction

  // Request seen in cycle j and accepted: schedule the whole line.
  task automatic model_accept(input int j, input int ln);
    int row, prev;
    if (j + 700 >= NCYC) begin
      n_cmp++; n_bad++;
      $display("FAIL model_range cyc=%0d actual=%0d required<%0d", j, j + 700, NCYC);
      return;
    end
    if (ln >= int'(TOP) && ln < int'(TOP) + 480) begin
      for (int k = j + 1; k <= j + 642; k++) exp_busy[k] = 1'b1;
      exp_done[j + 642] = 1'b1;
      for (int i = 0; i < 639; i++) exp_raddr[j + 1 + i] = 10'(i + 1);
      for (int x = 0; x < 640; x++) begin
        row  = row_of(smp_mem[x]);
        prev = (x == 0) ? row : row_of(smp_mem[x - 1]);
        exp_q.push_back({10'(x), colour_of(x, prev, row, ln)});
        exp_cyc_q.push_back(j + 2 + x);
      end
    end else begin
      exp_done[j + 1] = 1'b1;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk_sys) begin
    int  j;
    bit  exp_ovr;
    bit  exp_wen;
    j = cyc;
    exp_ovr = 1'b0;
    if (!rst_n) begin
      for (int k = j; k < NCYC; k++) begin
        exp_busy[k] = 1'b0; exp_done[k] = 1'b0; exp_raddr[k] = '0;
      end
      exp_q.delete();
      exp_cyc_q.delete();
    end else if (line_start) begin
      if (!exp_busy[j] || exp_done[j]) model_accept(j, int'(line_num));
      else exp_ovr = 1'b1;
    end
    chk("busy", 32'(busy), 32'(exp_busy[j]));
    chk("done", 32'(done), 32'(exp_done[j]));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    chk("smp_raddr", 32'(smp_raddr), 32'(exp_raddr[j]));
    exp_wen = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == j);
    chk("ram_wen", 32'(ram_wen), 32'(exp_wen));
    if (exp_wen) begin
      if (ram_wen) chk("pixel", 32'({ram_waddr, ram_wdata}), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    if (ram_wen) begin
      wr_cnt++;
      if (ram_wdata == TRACE) trace_cnt++;
      if (ram_wdata == GRID) grid_cnt++;
      if (ram_wdata == 16'h0000) zero_cnt++;
      if (ram_waddr < 10'd640) cap[ram_waddr] = ram_wdata;
    end
    if (busy) busy_cnt++;
    if (overrun) begin ovr_cnt++; ovr_cyc = j; end
    if (done) done_cyc = j;
  end

  // ---------------- driver tasks ----------------
  task automatic advance(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic start(input logic [9:0] ln);
    line_num   = ln;
    line_start = 1'b1;
    start_cyc  = cyc;
    advance(1);
    line_start = 1'b0;
  endtask

  task automatic clr_counts();
    wr_cnt = 0; trace_cnt = 0; grid_cnt = 0; zero_cnt = 0;
    busy_cnt = 0; ovr_cnt = 0; ovr_cyc = -1; done_cyc = -1;
  endtask

  task automatic fill_flat(input logic [7:0] v);
    for (int x = 0; x < 640; x++) smp_mem[x] = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    fill_flat(8'h80);
    clr_counts();
    advance(3);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wen", 32'(ram_wen), 32'd0);
    chk("reset_raddr", 32'(smp_raddr), 32'd0);
    rst_n = 1'b1;
    advance(3);

    // Flat mid-scale samples sit on row 269.
    clr_counts();
    start(10'd269);
    advance(650);
    chk("flat269_writes", 32'(wr_cnt), 32'd640);
    chk("flat269_trace", 32'(trace_cnt), 32'd640);

    clr_counts();
    start(10'd270);
    advance(650);
    chk("flat270_writes", 32'(wr_cnt), 32'd640);
    chk("flat270_trace", 32'(trace_cnt), 32'd0);

    // Step from row 142 to row 397 between pixels 319 and 320.
    for (int x = 0; x < 640; x++) smp_mem[x] = (x < 320) ? 8'hFF : 8'h00;
    clr_counts();
    start(10'd300);
    advance(650);
    chk("step_px319", 32'(cap[319]), 32'h0000);
    chk("step_px320", 32'(cap[320]), 32'(TRACE));
    chk("step_px321", 32'(cap[321]), 32'h0000);

    // Lines outside the active window.
    clr_counts();
    t0 = cyc;
    start(10'd10);
    advance(5);
    chk("inactive_done_cyc", 32'(done_cyc), 32'(t0 + 1));
    chk("inactive_writes", 32'(wr_cnt), 32'd0);
    chk("inactive_busy", 32'(busy_cnt), 32'd0);
    clr_counts();
    start(10'd29);
    advance(3);
    start(10'd510);
    advance(3);
    chk("edge_inactive_writes", 32'(wr_cnt), 32'd0);

    // Overrun mid-line, then back-to-back acceptance on done.
    for (int x = 0; x < 640; x++) smp_mem[x] = 8'((x * 7) & 255);
    clr_counts();
    t0 = cyc;
    start(10'd100);
    advance(99);
    start(10'd200);
    advance(541);
    start(10'd150);
    chk("ovr_count", 32'(ovr_cnt), 32'd1);
    chk("ovr_cyc", 32'(ovr_cyc), 32'(t0 + 100));
    chk("first_done_cyc", 32'(done_cyc), 32'(t0 + 642));
    chk("b2b_busy", 32'(busy), 32'd1);
    advance(650);
    chk("b2b_total_writes", 32'(wr_cnt), 32'd1280);

    // Reset in the middle of a line.
    fill_flat(8'h80);
    start(10'd269);
    advance(299);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_wen", 32'(ram_wen), 32'd0);
    chk("rst_mid_waddr", 32'(ram_waddr), 32'd0);
    chk("rst_mid_wdata", 32'(ram_wdata), 32'd0);
    advance(3);
    rst_n = 1'b1;
    clr_counts();
    advance(60);
    chk("post_rst_writes", 32'(wr_cnt), 32'd0);
    chk("post_rst_busy", 32'(busy_cnt), 32'd0);
    clr_counts();
    start(10'd269);
    advance(650);
    chk("post_rst_line_trace", 32'(trace_cnt), 32'd640);

    // Grid line: row 94 is 64 lines into the active area, trace sits at row 397.
    fill_flat(8'h00);
    clr_counts();
    start(10'd94);
    advance(650);
`ifdef WAVE_GRID_EN
    chk("grid_line_pixels", 32'(grid_cnt), 32'd640);
`else
    chk("grid_line_pixels", 32'(zero_cnt), 32'd640);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
